phase_accumulator: RTL and testbench
====================================

# phase_accumulator

Programmable phase accumulator (NCO front end) that generates the 9-bit sample index for the quarter-wave sine lookup stage in place of its free-running counter. Output frequency is set by a tuning word loaded through a valid/ready handshake, and output sample rate by a clock prescaler. A new tuning word takes effect only at an accumulator wrap, so frequency changes occur at a phase-zero boundary without a discontinuity.

## Interface

- ACC_WIDTH, 24: accumulator and tuning-word width.
- PHASE_WIDTH, 9: phase output width; top PHASE_WIDTH bits of accumulator.
- DIV_WIDTH, 16: prescaler divisor width.

- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  run enable; low freezes prescaler and accumulator.
- sample_div  input  DIV_WIDTH  one sample tick every sample_div+1 enabled cycles.
- tw_data  input  ACC_WIDTH  tuning word offered for load.
- tw_valid  input  1  tw_data valid.
- tw_ready  output  1  block can accept a tuning word.
- phase  output  PHASE_WIDTH  acc[ACC_WIDTH-1 -: PHASE_WIDTH], registered.
- sample_tick  output  1  one-cycle pulse, high in the cycle a new phase value first appears.
- wrap  output  1  one-cycle pulse, high with sample_tick when that update overflowed the accumulator.

## Operation

- Registers: acc (ACC_WIDTH), div_cnt (DIV_WIDTH), tw_active, tw_pending (ACC_WIDTH), pending (1), sample_tick, wrap.
- Reset: acc=0, div_cnt=0, tw_active=0, tw_pending=0, pending=0, sample_tick=0, wrap=0; hence phase=0, tw_ready=1. tw_valid ignored while rst high.
- Prescaler: when en, if div_cnt >= sample_div then tick fires and div_cnt<=0, else div_cnt<=div_cnt+1. Use >= so lowering sample_div mid-count ticks immediately rather than running 2^DIV_WIDTH. sample_div=0 ticks every enabled cycle. en low: div_cnt held, no tick.
- On tick: {carry, acc} <= acc + tw_active (modulo 2^ACC_WIDTH); sample_tick<=1; wrap<=carry. Otherwise sample_tick<=0, wrap<=0.
- Load FSM, two states:
  - IDLE (pending=0): tw_ready=1. tw_valid&&tw_ready: tw_pending<=tw_data, go LOADED.
  - LOADED (pending=1): tw_ready=0. On a tick where carry=1, or on any tick while tw_active==0: tw_active<=tw_pending (used from the next tick), go IDLE.
- Applying tick uses the old tw_active for its own addition.
- First load after reset applies at the next tick (tw_active==0).
- tw_data=0 is legal: accumulator stalls; the next load applies at the next tick.

## Timing

- tw_ready = !pending (combinational from register). Accept in cycle N -> tw_ready low in N+1.
- Apply on tick edge in cycle M -> tw_ready high in M+1; a tw_valid in cycle M is not accepted (ready was low).
- Tick decided in cycle T -> phase, sample_tick, wrap updated and visible in T+1; sample_tick/wrap low in T+2 unless another tick.
- With sample_div=0 and en=1, sample_tick is continuously high and phase updates every cycle.
- Latency tw accept -> first phase step with new word: ≥ 2 cycles; bounded by next wrap.
- rst asserted mid-operation: all state returns to reset values on that edge, including any pending word (discarded).
- en low during LOADED: pending held, no apply until ticks resume.

## Test plan

- Reset, sample_div=0, en=1, load tw=0x008000 -> accepted, applied at next tick; phase 0,1,2,…,511,0; wrap high only with phase 0 every 512 ticks; sample_tick continuously high.
- sample_div=3, tw=0x008000 -> sample_tick one cycle in four; phase increments by 1 per pulse; phase constant between pulses.
- Running at tw=0x008000 with phase=100, load tw=0x010000 -> tw_ready low next cycle; phase continues +1 through 511->0 (wrap); subsequent steps +2 (0,2,4…); tw_ready high the cycle after the wrap edge.
- tw=0x800000, sample_div=0 -> phase alternates 0,256,0,256; wrap high every second sample_tick.
- en low for 10 cycles mid-run -> phase, div_cnt frozen, no sample_tick; resumes exactly where it stopped.
- tw_valid=1 with tw=0x008000 held while rst high, then rst mid-run with word pending -> nothing captured during reset; after reset phase=0, tw_ready=1, tw_active=0, pending word discarded.

Source files
------------

// File: rtl/phase_accumulator_if.sv
// phase_accumulator_if: tuning-word load channel (tw_data, tw_valid from master; tw_ready from slave)
interface phase_accumulator_if #(parameter int ACC_WIDTH = 24);
  logic [ACC_WIDTH-1:0] tw_data;
  logic                 tw_valid;
  logic                 tw_ready;
  modport master (output tw_data, tw_valid, input tw_ready);
  modport slave  (input tw_data, tw_valid, output tw_ready);
endinterface

// File: rtl/phase_accumulator.sv
// phase_accumulator: NCO phase accumulator; clk/rst, en, sample_div, tw (tuning-word channel) in; phase, sample_tick, wrap out
module phase_accumulator #(
  parameter int ACC_WIDTH   = 24,
  parameter int PHASE_WIDTH = 9,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [DIV_WIDTH-1:0]   sample_div,
  phase_accumulator_if.slave     tw,
  output logic [PHASE_WIDTH-1:0] phase,
  output logic                   sample_tick,
  output logic                   wrap
);
  typedef enum logic {IDLE, LOADED} state_t;
  state_t               state, state_nx;
  logic [ACC_WIDTH-1:0] acc, tw_active, tw_pending;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [ACC_WIDTH:0]   sum;
  logic                 tick, carry, accept, apply;
  assign tick     = en && (div_cnt >= sample_div);
  assign sum      = {1'b0, acc} + {1'b0, tw_active};
  assign carry    = sum[ACC_WIDTH];
  assign tw.tw_ready = (state == IDLE);
  assign accept   = tw.tw_valid && tw.tw_ready;
  assign phase    = acc[ACC_WIDTH-1 -: PHASE_WIDTH];
  always_comb begin
    apply    = (state == LOADED) && tick && (carry || tw_active == '0);
    state_nx = accept ? LOADED : apply ? IDLE : state;
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      div_cnt     <= '0;
      tw_active   <= '0;
      tw_pending  <= '0;
      sample_tick <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      sample_tick <= tick;
      wrap        <= tick && carry;
      if (en) div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) acc <= sum[ACC_WIDTH-1:0];
      if (accept) tw_pending <= tw.tw_data;
      if (apply) tw_active <= tw_pending;
    end
  end
endmodule

// File: tb/tb_phase_accumulator.sv
// tb_phase_accumulator: directed table and sequence checks for phase_accumulator
module tb_phase_accumulator;
  logic        clk = 1'b0;
  logic        rst, en;
  logic [15:0] sample_div;
  logic [8:0]  phase;
  logic        sample_tick, wrap;
  int          n_tests = 0, n_fail = 0;
  phase_accumulator_if #(.ACC_WIDTH(24)) tw_if();
  phase_accumulator dut (
    .clk(clk), .rst(rst), .en(en), .sample_div(sample_div), .tw(tw_if),
    .phase(phase), .sample_tick(sample_tick), .wrap(wrap)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic        rst, en, valid;
    logic [23:0] data;
    int          ph;
    logic        tk, wr, rdy;
  } vec_t;
  vec_t v [13];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_all(input string name, input int ph, input int tk, input int wr, input int rdy);
    chk({name, ".phase"}, int'(phase), ph);
    chk({name, ".tick"}, int'(sample_tick), tk);
    chk({name, ".wrap"}, int'(wrap), wr);
    chk({name, ".ready"}, int'(tw_if.tw_ready), rdy);
  endtask
  task automatic reset_dut();
    rst = 1'b1; en = 1'b1; tw_if.tw_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask
  initial begin
    int p;
    v[0]  = '{1'b1, 1'b1, 1'b1, 24'h800000, 0,   1'b0, 1'b0, 1'b1};
    v[1]  = '{1'b0, 1'b1, 1'b1, 24'h800000, 0,   1'b1, 1'b0, 1'b0};
    v[2]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 0,   1'b1, 1'b0, 1'b1};
    v[3]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 256, 1'b1, 1'b0, 1'b1};
    v[4]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 0,   1'b1, 1'b1, 1'b1};
    v[5]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 256, 1'b1, 1'b0, 1'b1};
    v[6]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 0,   1'b1, 1'b1, 1'b1};
    v[7]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 0,   1'b0, 1'b0, 1'b1};
    v[8]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 256, 1'b1, 1'b0, 1'b1};
    v[9]  = '{1'b0, 1'b1, 1'b1, 24'h008000, 0,   1'b1, 1'b1, 1'b0};
    v[10] = '{1'b1, 1'b1, 1'b1, 24'h008000, 0,   1'b0, 1'b0, 1'b1};
    v[11] = '{1'b0, 1'b1, 1'b0, 24'h000000, 0,   1'b1, 1'b0, 1'b1};
    v[12] = '{1'b0, 1'b1, 1'b0, 24'h000000, 0,   1'b1, 1'b0, 1'b1};
    rst = 1'b1; en = 1'b0; sample_div = 16'd0;
    tw_if.tw_valid = 1'b0; tw_if.tw_data = 24'h0;
    step();
    for (int i = 0; i < 13; i++) begin
      rst = v[i].rst; en = v[i].en;
      tw_if.tw_valid = v[i].valid; tw_if.tw_data = v[i].data;
      step();
      chk_all($sformatf("vec%0d", i), v[i].ph, int'(v[i].tk), int'(v[i].wr), int'(v[i].rdy));
    end
    reset_dut();
    tw_if.tw_valid = 1'b1; tw_if.tw_data = 24'h008000;
    step();
    tw_if.tw_valid = 1'b0;
    chk("seqA.accept_ready", int'(tw_if.tw_ready), 0);
    step();
    chk("seqA.apply_ready", int'(tw_if.tw_ready), 1);
    chk("seqA.apply_phase", int'(phase), 0);
    for (int i = 1; i <= 520; i++) begin
      step();
      chk("seqA.phase", int'(phase), i % 512);
      chk("seqA.wrap", int'(wrap), int'(i % 512 == 0));
      chk("seqA.tick", int'(sample_tick), 1);
    end
    reset_dut();
    tw_if.tw_valid = 1'b1; tw_if.tw_data = 24'h008000;
    step();
    tw_if.tw_valid = 1'b0;
    step();
    for (int i = 1; i <= 100; i++) step();
    chk("seqC.start_phase", int'(phase), 100);
    tw_if.tw_valid = 1'b1; tw_if.tw_data = 24'h010000;
    step();
    tw_if.tw_valid = 1'b0;
    chk("seqC.accept_phase", int'(phase), 101);
    chk("seqC.accept_ready", int'(tw_if.tw_ready), 0);
    p = 101;
    while (p != 0) begin
      step();
      p = (p + 1) % 512;
      chk("seqC.phase", int'(phase), p);
      chk("seqC.ready", int'(tw_if.tw_ready), int'(p == 0));
      chk("seqC.wrap", int'(wrap), int'(p == 0));
    end
    for (int k = 1; k <= 3; k++) begin
      step();
      chk_all("seqC.fast", 2 * k, 1, 0, 1);
    end
    sample_div = 16'd3;
    reset_dut();
    for (int k = 1; k <= 26; k++) begin
      tw_if.tw_valid = (k == 1); tw_if.tw_data = 24'h008000;
      step();
      chk("seqB.tick", int'(sample_tick), int'(k % 4 == 0));
      chk("seqB.phase", int'(phase), (k < 4) ? 0 : k / 4 - 1);
    end
    tw_if.tw_valid = 1'b0;
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("seqB.frozen_tick", int'(sample_tick), 0);
      chk("seqB.frozen_phase", int'(phase), 5);
    end
    en = 1'b1;
    step();
    chk("seqB.resume1_tick", int'(sample_tick), 0);
    step();
    chk("seqB.resume2_tick", int'(sample_tick), 1);
    chk("seqB.resume2_phase", int'(phase), 6);
    step();
    step();
    chk("seqB.mid_tick", int'(sample_tick), 0);
    sample_div = 16'd1;
    step();
    chk("seqB.lower_div_tick", int'(sample_tick), 1);
    chk("seqB.lower_div_phase", int'(phase), 7);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
